load_store_unit: RTL and testbench

Sits between the core's memory stage and the word-addressed data memory. Accepts byte, halfword and word loads and stores (RV32I funct3 encoding) and converts byte addresses to word indices. Sign- or zero-extends load data. The data memory has no byte enables, so sub-word stores are performed as read-modify-write sequences. Misaligned, out-of-range and illegal requests are rejected without touching memory.

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and a word-addressed data memory without byte enables.
// Define LSU_SUBWORD_STORE_EN to enable SB/SH via read-modify-write; otherwise they are rejected.
module load_store_unit #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_read_data
);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        req_bad;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        req_bad = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            req_bad = 1'b1;
        if (req_we && (req_funct3 == 3'b100 || req_funct3 == 3'b101))
            req_bad = 1'b1;
`ifdef LSU_SUBWORD_STORE_EN
`else
        if (req_we && req_funct3[2:1] == 2'b00)
            req_bad = 1'b1;
`endif
        // funct3[1:0] == 01 covers both H and HU
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_bad = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            req_bad = 1'b1;
        if (req_addr >= ADDR_LIMIT)
            req_bad = 1'b1;
    end

    assign rd_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = mem_read_data[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'h0, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_ext = {16'h0, rd_half};
            default: load_ext = mem_read_data;
        endcase
    end

`ifdef LSU_SUBWORD_STORE_EN
    logic [31:0] merged;
    always_comb begin
        merged = mem_read_data;
        if (funct3_q[0])
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_bad) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: state_q <= MERGE;
                MERGE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= we_q ? 32'h0 : load_ext;
                end
                WR: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are pure state decodes so an asynchronous reset kills them immediately.
    always_comb begin
        mem_write_enable = (state_q == WR);
        mem_write_data   = (state_q == WR) ? wdata_q : 32'h0;
`ifdef LSU_SUBWORD_STORE_EN
        if (state_q == MERGE && we_q) begin
            mem_write_enable = 1'b1;
            mem_write_data   = merged;
        end
`endif
    end

    assign req_ready       = (state_q == IDLE);
    assign mem_read_enable = (state_q == RD);
    assign mem_address     = (state_q == IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_rdata      = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic against a byte-level reference.
// Expectations follow LSU_SUBWORD_STORE_EN the same way the design build does.
module tb_load_store_unit;
    localparam int DEPTH = 256;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          nrd;
        int          nwr;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data)
    );

    // Data memory driven by the DUT strobes, with a side port for preloading.
    logic [31:0] tmem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_data = 32'h0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    int n_tests = 0, n_fail = 0;

    always @(posedge clk) begin
        if (pre_we) tmem[pre_idx] <= pre_data;
        else if (mem_write_enable) tmem[mem_address[7:0]] <= mem_write_data;
        if (mem_read_enable) mem_read_data <= tmem[mem_address[7:0]];
        if (mem_read_enable) rd_cnt <= rd_cnt + 1;
        if (mem_write_enable) wr_cnt <= wr_cnt + 1;
        if (mem_read_enable && mem_write_enable) both_cnt <= both_cnt + 1;
    end

    // Reference: decode the request from the ISA rules, then act on ref_mem with shifts and masks.
    function automatic void ref_exec(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd, output res_t e);
        int size;
        bit sgn;
        logic [31:0] mask, word, val;
        int off;
        e = '{err: 1'b0, rd: 32'h0, lat: 1, nrd: 0, nwr: 0};
        size = 4; sgn = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: e.err = 1'b1;
        endcase
        if (we && (f3 == 3'd4 || f3 == 3'd5)) e.err = 1'b1;
`ifndef LSU_SUBWORD_STORE_EN
        if (we && size < 4) e.err = 1'b1;
`endif
        if ((a % size) != 0) e.err = 1'b1;
        if (a >= 4 * DEPTH) e.err = 1'b1;
        if (e.err) return;
        word = ref_mem[a / 4];
        off  = (a % 4) * 8;
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!we) begin
            val = (word >> off) & mask;
            if (sgn && val[size*8-1]) val = val | ~mask;
            e.rd = val; e.lat = 3; e.nrd = 1;
        end else if (size == 4) begin
            ref_mem[a / 4] = wd;
            e.lat = 2; e.nwr = 1;
        end else begin
            ref_mem[a / 4] = (word & ~(mask << off)) | ((wd & mask) << off);
            e.lat = 3; e.nrd = 1; e.nwr = 1;
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx[7:0]; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Issues one request, returns what the DUT did and what the reference says it should do.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output res_t o, output res_t e, output logic [31:0] raddr, output bit busy_ready);
        int r0, w0;
        ref_exec(we, f3, a, wd, e);
        o = '{err: 1'b0, rd: 32'h0, lat: -1, nrd: 0, nwr: 0};
        raddr = 32'hFFFF_FFFF;
        busy_ready = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
        r0 = rd_cnt; w0 = wr_cnt;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_read_enable) raddr = mem_address;
            if (resp_valid) begin
                o.lat = c; o.err = resp_err; o.rd = resp_rdata;
                break;
            end
            if (req_ready) busy_ready = 1;
        end
        o.nrd = rd_cnt - r0;
        o.nwr = wr_cnt - w0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({req_ready, resp_valid, resp_err, mem_read_enable, mem_write_enable} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 10000",
                {req_ready, resp_valid, resp_err, mem_read_enable, mem_write_enable});
        end
        n_tests++;
        if ({resp_rdata, mem_address, mem_write_data} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h expected 0", resp_rdata, mem_address, mem_write_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: ready %b valid %b expected 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3v [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] av  [5] = '{32'h4, 32'h7, 32'h7, 32'h6, 32'h4};
        logic [31:0] xv  [5] = '{32'h8899AABB, 32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
        res_t o, e;
        logic [31:0] ra;
        bit br;
        preload(1, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3v[i], av[i], $urandom, o, e, ra, br);
            n_tests++;
            if (o.err !== 1'b0 || o.rd !== xv[i]) begin
                n_fail++; $display("FAIL load_%0d_data: got err %b rdata %h expected err 0 rdata %h", i, o.err, o.rd, xv[i]);
            end
            n_tests++;
            if (o.lat != 3 || o.nrd != 1 || o.nwr != 0 || ra !== 32'h1) begin
                n_fail++; $display("FAIL load_%0d_timing: got lat %0d rd %0d wr %0d addr %h expected 3 1 0 00000001",
                    i, o.lat, o.nrd, o.nwr, ra);
            end
        end
    endtask

    task automatic test_subword_store;
        res_t o, e;
        logic [31:0] ra;
        bit br;
        do_req(1'b1, 3'd0, 32'h5, 32'h12345677, o, e, ra, br);
`ifdef LSU_SUBWORD_STORE_EN
        n_tests++;
        if (o.err !== 1'b0 || o.lat != 3 || o.nwr != 1 || tmem[1] !== 32'h889977BB) begin
            n_fail++; $display("FAIL sb: got err %b lat %0d wr %0d word %h expected 0 3 1 889977bb", o.err, o.lat, o.nwr, tmem[1]);
        end
        do_req(1'b1, 3'd1, 32'h6, 32'h0000CAFE, o, e, ra, br);
        n_tests++;
        if (o.err !== 1'b0 || o.lat != 3 || o.nwr != 1 || tmem[1] !== 32'hCAFE77BB) begin
            n_fail++; $display("FAIL sh: got err %b lat %0d wr %0d word %h expected 0 3 1 cafe77bb", o.err, o.lat, o.nwr, tmem[1]);
        end
`else
        n_tests++;
        if (o.err !== 1'b1 || o.lat != 1 || o.nwr != 0 || o.nrd != 0 || tmem[1] !== 32'h8899AABB) begin
            n_fail++; $display("FAIL sb_disabled: got err %b lat %0d wr %0d word %h expected 1 1 0 8899aabb", o.err, o.lat, o.nwr, tmem[1]);
        end
        do_req(1'b0, 3'd0, 32'h7, 32'h0, o, e, ra, br);
        n_tests++;
        if (o.err !== 1'b0 || o.rd !== 32'hFFFFFF88) begin
            n_fail++; $display("FAIL lb_disabled: got err %b rdata %h expected 0 ffffff88", o.err, o.rd);
        end
`endif
        do_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, o, e, ra, br);
        n_tests++;
        if (o.err !== 1'b0 || o.lat != 2 || o.nwr != 1 || o.nrd != 0 || tmem[2] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sw: got err %b lat %0d wr %0d rd %0d word %h expected 0 2 1 0 deadbeef",
                o.err, o.lat, o.nwr, o.nrd, tmem[2]);
        end
    endtask

    task automatic test_errors;
        logic        wev [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3v [4] = '{3'd2, 3'd1, 3'd2, 3'd3};
        logic [31:0] av  [4] = '{32'h6, 32'h3, 32'h400, 32'h0};
        res_t o, e;
        logic [31:0] ra;
        bit br;
        int diffs;
        for (int i = 0; i < 4; i++) begin
            do_req(wev[i], f3v[i], av[i], $urandom, o, e, ra, br);
            n_tests++;
            if (o.err !== 1'b1 || o.lat != 1 || o.rd !== 32'h0 || o.nrd != 0 || o.nwr != 0) begin
                n_fail++; $display("FAIL err_%0d: got err %b lat %0d rdata %h rd %0d wr %0d expected 1 1 0 0 0",
                    i, o.err, o.lat, o.rd, o.nrd, o.nwr);
            end
        end
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (tmem[i] !== ref_mem[i]) diffs++;
        n_tests++;
        if (diffs != 0) begin
            n_fail++; $display("FAIL err_mem: got %0d changed words expected 0", diffs);
        end
    endtask

    task automatic test_reset_mid;
        res_t o, e;
        logic [31:0] ra;
        bit br;
        int w0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h5; req_wdata = 32'h12345677;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef LSU_SUBWORD_STORE_EN
        n_tests++;
        if (mem_read_enable !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_rd: got read strobe %b expected 1", mem_read_enable);
        end
`endif
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, resp_valid, resp_err, mem_read_enable, mem_write_enable} !== 5'b10000 ||
            {resp_rdata, mem_address, mem_write_data} !== 96'h0) begin
            n_fail++; $display("FAIL rstmid_outs: got %b %h %h %h expected 10000 0 0 0",
                {req_ready, resp_valid, resp_err, mem_read_enable, mem_write_enable}, resp_rdata, mem_address, mem_write_data);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (wr_cnt != w0 || tmem[1] !== ref_mem[1]) begin
            n_fail++; $display("FAIL rstmid_mem: got %0d writes word %h expected 0 writes word %h", wr_cnt - w0, tmem[1], ref_mem[1]);
        end
        rst_n = 1'b1;
        do_req(1'b0, 3'd2, 32'h4, 32'h0, o, e, ra, br);
        n_tests++;
        if (o.err !== 1'b0 || o.rd !== ref_mem[1] || o.lat != 3) begin
            n_fail++; $display("FAIL rstmid_lw: got err %b rdata %h lat %0d expected 0 %h 3", o.err, o.rd, o.lat, ref_mem[1]);
        end
    endtask

    task automatic test_back_to_back;
        logic        wev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3v [4] = '{3'd0, 3'd4, 3'd2, 3'd2};
        logic [31:0] av  [4] = '{32'h9, 32'h9, 32'hC, 32'hC};
        res_t o, e;
        logic [31:0] ra;
        bit br;
        for (int i = 0; i < 4; i++) begin
            do_req(wev[i], f3v[i], av[i], $urandom, o, e, ra, br);
            n_tests++;
            if (o.err !== e.err || o.rd !== e.rd || o.lat != e.lat || br) begin
                n_fail++; $display("FAIL b2b_%0d: got err %b rdata %h lat %0d busy_ready %0d expected %b %h %0d 0",
                    i, o.err, o.rd, o.lat, br, e.err, e.rd, e.lat);
            end
        end
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b expected 1 after response", req_ready);
        end
    endtask

    task automatic test_random;
        res_t o, e;
        logic [31:0] ra, a;
        logic we;
        logic [2:0] f3;
        bit br;
        int sel;
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel < 8) a = $urandom_range(0, 31);
            else if (sel == 8) a = $urandom_range(1020, 1100);
            else a = $urandom;
            do_req(we, f3, a, $urandom, o, e, ra, br);
            n_tests++;
            if (o.err !== e.err || o.rd !== e.rd) begin
                n_fail++; $display("FAIL rnd_%0d_resp: we %b f3 %0d addr %h got err %b rdata %h expected %b %h",
                    i, we, f3, a, o.err, o.rd, e.err, e.rd);
            end
            n_tests++;
            if (o.lat != e.lat || o.nrd != e.nrd || o.nwr != e.nwr || br) begin
                n_fail++; $display("FAIL rnd_%0d_timing: got lat %0d rd %0d wr %0d busy_ready %0d expected %0d %0d %0d 0",
                    i, o.lat, o.nrd, o.nwr, br, e.lat, e.nrd, e.nwr);
            end
            if (a < 32'd1024) begin
                n_tests++;
                if (tmem[a[9:2]] !== ref_mem[a[9:2]]) begin
                    n_fail++; $display("FAIL rnd_%0d_mem: word %0d got %h expected %h", i, a[9:2], tmem[a[9:2]], ref_mem[a[9:2]]);
                end
            end
        end
    endtask

    task automatic test_strobes;
        n_tests++;
        if (both_cnt != 0) begin
            n_fail++; $display("FAIL strobe_overlap: got %0d cycles with both strobes expected 0", both_cnt);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        test_reset;
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
        test_loads;
        test_subword_store;
        test_errors;
        test_reset_mid;
        test_back_to_back;
        test_random;
        test_strobes;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
